// File: rtl/bus_arbiter_mux_if.sv
// Shared-bus signal bundle for the four-master arbiter/mux.
// The master modport is the masters' view of the bundle; the slave modport is the arbiter's view.
interface bus_arbiter_mux_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              m0_req_,    m1_req_,    m2_req_,    m3_req_;
  logic              m0_grnt_,   m1_grnt_,   m2_grnt_,   m3_grnt_;
  logic [ADDR_W-1:0] m0_addr,    m1_addr,    m2_addr,    m3_addr;
  logic              m0_as_,     m1_as_,     m2_as_,     m3_as_;
  logic              m0_rw,      m1_rw,      m2_rw,      m3_rw;
  logic [DATA_W-1:0] m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data;
  logic [ADDR_W-1:0] s_addr;
  logic              s_as_;
  logic              s_rw;
  logic [DATA_W-1:0] s_wr_data;

  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_,
    output m0_addr, m1_addr, m2_addr, m3_addr,
    output m0_as_, m1_as_, m2_as_, m3_as_,
    output m0_rw, m1_rw, m2_rw, m3_rw,
    output m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data,
    input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_,
    input  s_addr, s_as_, s_rw, s_wr_data
  );

  modport slave (
    input  m0_req_, m1_req_, m2_req_, m3_req_,
    input  m0_addr, m1_addr, m2_addr, m3_addr,
    input  m0_as_, m1_as_, m2_as_, m3_as_,
    input  m0_rw, m1_rw, m2_rw, m3_rw,
    input  m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data,
    output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_,
    output s_addr, s_as_, s_rw, s_wr_data
  );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Round-robin arbiter for four bus masters with a master-to-shared-bus multiplexer.
// Ownership is the only state; grants and the bus mux decode it combinationally.
module bus_arbiter_mux #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input logic             clk,
  input logic             reset,
  bus_arbiter_mux_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_M0 = 2'd0,
    OWN_M1 = 2'd1,
    OWN_M2 = 2'd2,
    OWN_M3 = 2'd3
  } owner_e;

  owner_e            owner_r;
  owner_e            owner_nxt_s;
  logic [3:0]        req_n_s;
  logic [1:0]        cand_s;
  logic              found_s;
  logic [ADDR_W-1:0] addr_mux_s;
  logic              as_mux_s;
  logic              rw_mux_s;
  logic [DATA_W-1:0] wr_data_mux_s;

  assign req_n_s = {bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};

  // Ownership register; reset parks the bus on master 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_r <= OWN_M0;
    end else begin
      owner_r <= owner_nxt_s;
    end
  end

  // Next owner: hold while the owner requests, otherwise search owner+1..owner+3.
  always_comb begin
    owner_nxt_s = owner_r;
    cand_s      = 2'd0;
    found_s     = 1'b0;
    if (req_n_s[owner_r] == 1'b1) begin
      for (int i = 1; i < 4; i++) begin
        cand_s = owner_r + 2'(i);
        if (!found_s && (req_n_s[cand_s] == 1'b0)) begin
          owner_nxt_s = owner_e'(cand_s);
          found_s     = 1'b1;
        end
      end
    end else begin
      owner_nxt_s = owner_r;
    end
  end

  assign bus.m0_grnt_ = (owner_r != OWN_M0);
  assign bus.m1_grnt_ = (owner_r != OWN_M1);
  assign bus.m2_grnt_ = (owner_r != OWN_M2);
  assign bus.m3_grnt_ = (owner_r != OWN_M3);

  // Shared-bus multiplexer: only the owner's access (and strobe) reaches the slaves.
  always_comb begin
    addr_mux_s    = bus.m0_addr;
    as_mux_s      = bus.m0_as_;
    rw_mux_s      = bus.m0_rw;
    wr_data_mux_s = bus.m0_wr_data;
    case (owner_r)
      OWN_M0: begin
        addr_mux_s    = bus.m0_addr;
        as_mux_s      = bus.m0_as_;
        rw_mux_s      = bus.m0_rw;
        wr_data_mux_s = bus.m0_wr_data;
      end
      OWN_M1: begin
        addr_mux_s    = bus.m1_addr;
        as_mux_s      = bus.m1_as_;
        rw_mux_s      = bus.m1_rw;
        wr_data_mux_s = bus.m1_wr_data;
      end
      OWN_M2: begin
        addr_mux_s    = bus.m2_addr;
        as_mux_s      = bus.m2_as_;
        rw_mux_s      = bus.m2_rw;
        wr_data_mux_s = bus.m2_wr_data;
      end
      OWN_M3: begin
        addr_mux_s    = bus.m3_addr;
        as_mux_s      = bus.m3_as_;
        rw_mux_s      = bus.m3_rw;
        wr_data_mux_s = bus.m3_wr_data;
      end
      default: begin
        addr_mux_s    = bus.m0_addr;
        as_mux_s      = bus.m0_as_;
        rw_mux_s      = bus.m0_rw;
        wr_data_mux_s = bus.m0_wr_data;
      end
    endcase
  end

  assign bus.s_addr    = addr_mux_s;
  assign bus.s_as_     = as_mux_s;
  assign bus.s_rw      = rw_mux_s;
  assign bus.s_wr_data = wr_data_mux_s;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Self-checking bench for bus_arbiter_mux: directed sequences, a vector table for
// round-robin and hold behaviour, and randomized traffic against an ownership model.
module tb_bus_arbiter_mux;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  typedef struct {
    logic [3:0] req_n;
    logic [3:0] exp_grnt_n;
    string      name;
  } vec_t;

  logic              clk;
  logic              reset;
  logic [3:0]        req_n;
  logic [ADDR_W-1:0] addr    [4];
  logic [3:0]        as_n;
  logic [3:0]        rw;
  logic [DATA_W-1:0] wr_data [4];
  logic [3:0]        grnt_n;

  int n_checks;
  int n_fail;
  int mown;

  bus_arbiter_mux_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bus_arbiter_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.m0_req_ = req_n[0];
  assign bus.m1_req_ = req_n[1];
  assign bus.m2_req_ = req_n[2];
  assign bus.m3_req_ = req_n[3];
  assign bus.m0_addr = addr[0];
  assign bus.m1_addr = addr[1];
  assign bus.m2_addr = addr[2];
  assign bus.m3_addr = addr[3];
  assign bus.m0_as_  = as_n[0];
  assign bus.m1_as_  = as_n[1];
  assign bus.m2_as_  = as_n[2];
  assign bus.m3_as_  = as_n[3];
  assign bus.m0_rw   = rw[0];
  assign bus.m1_rw   = rw[1];
  assign bus.m2_rw   = rw[2];
  assign bus.m3_rw   = rw[3];
  assign bus.m0_wr_data = wr_data[0];
  assign bus.m1_wr_data = wr_data[1];
  assign bus.m2_wr_data = wr_data[2];
  assign bus.m3_wr_data = wr_data[3];
  assign grnt_n = {bus.m3_grnt_, bus.m2_grnt_, bus.m1_grnt_, bus.m0_grnt_};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: hold while the owner requests, else the nearest requester in round-robin order.
  function automatic int next_owner(input int cur, input logic [3:0] r_n, input logic rst_ok);
    if (!rst_ok) return 0;
    if (r_n[cur] == 1'b0) return cur;
    for (int d = 1; d <= 3; d++) begin
      if (r_n[(cur + d) % 4] == 1'b0) return (cur + d) % 4;
    end
    return cur;
  endfunction

  function automatic logic [3:0] grant_of(input int own);
    logic [3:0] g;
    g = 4'b1111;
    g[own] = 1'b0;
    return g;
  endfunction

  // Advance one clock, update the model with the inputs sampled at that edge.
  task automatic step();
    @(posedge clk);
    mown = next_owner(mown, req_n, reset);
    #1;
  endtask

  vec_t vecs[$];

  task automatic push(input logic [3:0] r, input int own, input string nm);
    vec_t v;
    v.req_n      = r;
    v.exp_grnt_n = grant_of(own);
    v.name       = nm;
    vecs.push_back(v);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mown     = 0;
    reset    = 1'b0;
    req_n    = 4'b1111;
    as_n     = 4'b1111;
    rw       = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      addr[i]    = ADDR_W'(32'h100 * (i + 1));
      wr_data[i] = DATA_W'(32'h1111_1111 * (i + 1));
    end
    addr[0] = 30'h123;

    // Round-robin fairness table (starts with master 1 owning, all requesting).
    for (int k = 0; k < 3; k++) push(4'b0000, 1, "rr_hold1");
    push(4'b0010, 2, "rr_to2");
    for (int k = 0; k < 3; k++) push(4'b0000, 2, "rr_hold2");
    push(4'b0100, 3, "rr_to3");
    for (int k = 0; k < 3; k++) push(4'b0000, 3, "rr_hold3");
    push(4'b1000, 0, "rr_to0");
    for (int k = 0; k < 3; k++) push(4'b0000, 0, "rr_hold0");
    push(4'b0001, 1, "rr_to1");
    for (int k = 0; k < 3; k++) push(4'b0000, 1, "rr_hold1b");
    push(4'b0010, 2, "rr_to2b");
    // Hold / no preemption: m2 keeps the bus while m0 and m3 wait.
    for (int k = 0; k < 20; k++) push(4'b0010, 2, "hold_m2");
    push(4'b0110, 3, "hold_to3");
    push(4'b1110, 0, "hold_to0");

    // Test 1: reset and idle parking on master 0.
    #2;
    chk("rst_grnt", 64'(grnt_n), 64'(4'b1110));
    for (int k = 0; k < 3; k++) step();
    chk("rst_grnt_3cyc", 64'(grnt_n), 64'(4'b1110));
    chk("rst_s_addr", 64'(bus.s_addr), 64'(30'h123));
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("idle_park0", 64'(grnt_n), 64'(4'b1110));
    end

    // Test 2: single request hands the bus to master 1 after one edge.
    addr[1] = 30'h0400_0000;
    as_n[1] = 1'b0;
    req_n   = 4'b1101;
    chk("req1_not_yet", 64'(grnt_n), 64'(4'b1110));
    step();
    chk("req1_grnt", 64'(grnt_n), 64'(4'b1101));
    chk("req1_s_addr", 64'(bus.s_addr), 64'(30'h0400_0000));
    chk("req1_s_as", 64'(bus.s_as_), 64'(1'b0));
    for (int k = 0; k < 3; k++) step();
    req_n = 4'b1111;
    step();
    chk("req1_park", 64'(grnt_n), 64'(4'b1101));
    as_n[1] = 1'b1;

    // Tests 3 and 4: table-driven round robin and hold.
    foreach (vecs[i]) begin
      req_n = vecs[i].req_n;
      step();
      chk(vecs[i].name, 64'(grnt_n), 64'(vecs[i].exp_grnt_n));
      chk({vecs[i].name, "_model"}, 64'(grant_of(mown)), 64'(vecs[i].exp_grnt_n));
    end

    // Test 5: strobe isolation while master 0 owns the bus.
    req_n      = 4'b1110;
    step();
    as_n       = 4'b0111;
    wr_data[0] = 32'h0BAD_F00D;
    wr_data[3] = 32'hDEAD_BEEF;
    #1;
    chk("iso_grnt", 64'(grnt_n), 64'(4'b1110));
    chk("iso_s_as", 64'(bus.s_as_), 64'(1'b1));
    chk("iso_s_wr_data", 64'(bus.s_wr_data), 64'(32'h0BAD_F00D));

    // Test 6: asynchronous reset in the middle of master 3's access.
    req_n = 4'b0111;
    step();
    chk("m3_grnt", 64'(grnt_n), 64'(4'b0111));
    chk("m3_s_as", 64'(bus.s_as_), 64'(1'b0));
    chk("m3_s_wr_data", 64'(bus.s_wr_data), 64'(32'hDEAD_BEEF));
    #2;
    reset = 1'b0;
    mown  = 0;
    #1;
    chk("async_rst_grnt", 64'(grnt_n), 64'(4'b1110));
    chk("async_rst_s_as", 64'(bus.s_as_), 64'(1'b1));
    step();
    reset = 1'b1;
    req_n = 4'b1111;
    as_n  = 4'b1111;
    step();

    // Randomized traffic against the ownership model.
    for (int k = 0; k < 400; k++) begin
      req_n = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        addr[i]    = ADDR_W'($urandom);
        wr_data[i] = DATA_W'($urandom);
      end
      as_n = 4'($urandom_range(0, 15));
      rw   = 4'($urandom_range(0, 15));
      step();
      chk("rand_grnt", 64'(grnt_n), 64'(grant_of(mown)));
      chk("rand_s_addr", 64'(bus.s_addr), 64'(addr[mown]));
      chk("rand_s_as", 64'(bus.s_as_), 64'(as_n[mown]));
      chk("rand_s_rw", 64'(bus.s_rw), 64'(rw[mown]));
      chk("rand_s_wr_data", 64'(bus.s_wr_data), 64'(wr_data[mown]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
